// File: rtl/tx_bit_feeder.sv
// Byte FIFO feeding an LSB-first serialiser for the Ethernet TX path.
// Arms a sticky 'start' once START_LEVEL bytes are buffered and flags low-water/overflow/underrun.
module tx_bit_feeder #(
    parameter int AW          = 6,
    parameter int START_LEVEL = 16,
    parameter int LOW_LEVEL   = 24
) (
    input  logic          ff_clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          wr_full,
    output logic          ff_en,
    output logic          ff_data,
    output logic          start,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          underrun
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] START_L = (AW+1)'(START_LEVEL);
    localparam logic [AW:0] LOW_L   = (AW+1)'(LOW_LEVEL);
    localparam logic [AW:0] ONE_L   = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, STARVE} state_t;

    state_t          state;
    state_t          next_state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     level_q;
    logic [7:0]      sh;
    logic [2:0]      bit_cnt;
    logic            wr_accept;
    logic            level_nz;
    logic            pop;
    logic            ff_en_nx;
    logic            ff_data_nx;

    // Both flags come from the registered level, so a write in the full cycle is dropped even if a pop frees a slot.
    assign wr_full   = (level_q == DEPTH_L);
    assign empty     = (level_q < LOW_L);
    assign level     = level_q;
    assign level_nz  = (level_q != '0);
    assign wr_accept = wr_en && !wr_full;

    always_ff @(posedge ff_clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (level_q >= START_L) begin
                    pop        = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (bit_cnt == 3'd7) begin
                    if (level_nz)
                        pop = 1'b1;
                    else
                        next_state = STARVE;
                end
            end
            STARVE: begin
                if (level_nz) begin
                    pop        = 1'b1;
                    next_state = RUN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ff_en_nx   = 1'b0;
        ff_data_nx = ff_data;
        if (state == RUN) begin
            ff_en_nx   = 1'b1;
            ff_data_nx = sh[0];
        end
    end

    always_ff @(posedge ff_clk) begin
        if (wr_accept)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge ff_clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            sh       <= '0;
            bit_cnt  <= '0;
            ff_en    <= 1'b0;
            ff_data  <= 1'b0;
            start    <= 1'b0;
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            ff_en   <= ff_en_nx;
            ff_data <= ff_data_nx;
            if (wr_accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (wr_en && wr_full)
                overflow <= 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_accept && !pop)
                level_q <= level_q + ONE_L;
            else if (pop && !wr_accept)
                level_q <= level_q - ONE_L;
            if (state == RUN) begin
                sh      <= sh >> 1;
                bit_cnt <= bit_cnt + 3'd1;
            end
            // A pop reloads the shifter; on the bit-7 cycle this keeps the bit stream gapless.
            if (pop) begin
                sh      <= mem[rd_ptr];
                bit_cnt <= 3'd0;
            end
            if (state == IDLE && pop)
                start <= 1'b1;
            if (state == RUN && bit_cnt == 3'd7 && !level_nz)
                underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_bit_feeder.sv
// Directed bench for tx_bit_feeder: bit scoreboard fed from writes, checked on every ff_en cycle.
// A second instance with START_LEVEL=64 exercises full/overflow and pointer wrap.
module tb_tx_bit_feeder;

    logic        ff_clk;
    logic        reset;
    logic        wr_en_a, wr_en_b;
    logic [7:0]  wr_data_a, wr_data_b;
    logic        wr_full_a, wr_full_b;
    logic        ff_en_a, ff_en_b;
    logic        ff_data_a, ff_data_b;
    logic        start_a, start_b;
    logic        empty_a, empty_b;
    logic [6:0]  level_a, level_b;
    logic        overflow_a, overflow_b;
    logic        underrun_a, underrun_b;

    int vectors = 0;
    int miscompares = 0;
    int step_no = 0;
    int en_count_a = 0;
    int en_count_b = 0;
    int first_en_a = -1;
    int last_en_a = -1;
    bit qa[$];
    bit qb[$];

    tx_bit_feeder #(.AW(6), .START_LEVEL(16), .LOW_LEVEL(24)) u_a (
        .ff_clk(ff_clk), .reset(reset), .wr_en(wr_en_a), .wr_data(wr_data_a),
        .wr_full(wr_full_a), .ff_en(ff_en_a), .ff_data(ff_data_a), .start(start_a),
        .empty(empty_a), .level(level_a), .overflow(overflow_a), .underrun(underrun_a)
    );

    tx_bit_feeder #(.AW(6), .START_LEVEL(64), .LOW_LEVEL(24)) u_b (
        .ff_clk(ff_clk), .reset(reset), .wr_en(wr_en_b), .wr_data(wr_data_b),
        .wr_full(wr_full_b), .ff_en(ff_en_b), .ff_data(ff_data_b), .start(start_b),
        .empty(empty_b), .level(level_b), .overflow(overflow_b), .underrun(underrun_b)
    );

    initial ff_clk = 1'b0;
    always #5 ff_clk = ~ff_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pushByte(input logic [7:0] b, input logic to_b);
        for (int i = 0; i < 8; i++) begin
            if (to_b) qb.push_back(b[i]);
            else      qa.push_back(b[i]);
        end
    endtask

    // One clock; outputs are sampled on the falling edge and every serial bit is scored.
    task automatic applyStimulus();
        bit exp_bit;
        @(posedge ff_clk);
        @(negedge ff_clk);
        step_no++;
        if (ff_en_a) begin
            en_count_a++;
            if (first_en_a < 0) first_en_a = step_no;
            last_en_a = step_no;
            if (qa.size() == 0) begin
                checkOutput("a_unexpected_bit", 32'(ff_en_a), 32'd0);
            end else begin
                exp_bit = qa.pop_front();
                checkOutput("a_bit", 32'(ff_data_a), 32'(exp_bit));
            end
        end
        if (ff_en_b) begin
            en_count_b++;
            if (qb.size() == 0) begin
                checkOutput("b_unexpected_bit", 32'(ff_en_b), 32'd0);
            end else begin
                exp_bit = qb.pop_front();
                checkOutput("b_bit", 32'(ff_data_b), 32'(exp_bit));
            end
        end
    endtask

    initial begin
        int exp_level;
        int en_before;
        reset = 1'b1;
        wr_en_a = 1'b0; wr_data_a = 8'h00;
        wr_en_b = 1'b0; wr_data_b = 8'h00;
        repeat (3) applyStimulus();
        checkOutput("rst_ff_en", 32'(ff_en_a), 32'd0);
        checkOutput("rst_start", 32'(start_a), 32'd0);
        checkOutput("rst_level", 32'(level_a), 32'd0);
        checkOutput("rst_empty", 32'(empty_a), 32'd1);
        checkOutput("rst_full", 32'(wr_full_a), 32'd0);
        checkOutput("rst_overflow", 32'(overflow_a), 32'd0);
        checkOutput("rst_underrun", 32'(underrun_a), 32'd0);
        reset = 1'b0;
        step_no = 0;

        // Arm and seamless streaming: 32 bytes, pops at steps 17, 25, ... .
        for (int n = 1; n <= 32; n++) begin
            wr_en_a = 1'b1;
            wr_data_a = 8'(n);
            pushByte(8'(n), 1'b0);
            applyStimulus();
            exp_level = n - ((n >= 17) ? 1 : 0) - ((n >= 25) ? 1 : 0);
            checkOutput("arm_level", 32'(level_a), 32'(exp_level));
            checkOutput("arm_empty", 32'(empty_a), (exp_level < 24) ? 32'd1 : 32'd0);
            if (n == 16) checkOutput("arm_start_pre", 32'(start_a), 32'd0);
            if (n == 17) begin
                checkOutput("arm_start", 32'(start_a), 32'd1);
                checkOutput("arm_en_pre", 32'(ff_en_a), 32'd0);
            end
            if (n == 18) checkOutput("arm_en_rise", 32'(ff_en_a), 32'd1);
        end
        wr_en_a = 1'b0;
        while (step_no < 274) begin
            applyStimulus();
            if (step_no == 73) begin
                checkOutput("drain_level24", 32'(level_a), 32'd24);
                checkOutput("drain_empty24", 32'(empty_a), 32'd0);
            end
            if (step_no == 81) begin
                checkOutput("drain_level23", 32'(level_a), 32'd23);
                checkOutput("drain_empty23", 32'(empty_a), 32'd1);
            end
        end
        checkOutput("seam_first_en", 32'(first_en_a), 32'd18);
        checkOutput("seam_en_count", 32'(en_count_a), 32'd256);
        checkOutput("seam_span", 32'(last_en_a - first_en_a + 1), 32'd256);
        checkOutput("seam_en_fall", 32'(ff_en_a), 32'd0);
        checkOutput("seam_underrun", 32'(underrun_a), 32'd1);
        checkOutput("seam_queue", 32'(qa.size()), 32'd0);

        // Resume from starvation with a single byte.
        wr_en_a = 1'b1; wr_data_a = 8'hA5;
        pushByte(8'hA5, 1'b0);
        applyStimulus();
        wr_en_a = 1'b0;
        checkOutput("resume_en_w0", 32'(ff_en_a), 32'd0);
        applyStimulus();
        checkOutput("resume_en_w1", 32'(ff_en_a), 32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus();
            checkOutput("resume_en_bit", 32'(ff_en_a), 32'd1);
        end
        applyStimulus();
        checkOutput("resume_en_fall", 32'(ff_en_a), 32'd0);
        checkOutput("resume_queue", 32'(qa.size()), 32'd0);

        // Reset in the middle of a running byte discards everything.
        for (int i = 0; i < 3; i++) begin
            wr_en_a = 1'b1;
            wr_data_a = (i == 0) ? 8'h3C : ((i == 1) ? 8'hC3 : 8'h5A);
            pushByte(wr_data_a, 1'b0);
            applyStimulus();
        end
        wr_en_a = 1'b0;
        repeat (3) applyStimulus();
        checkOutput("midrun_en", 32'(ff_en_a), 32'd1);
        reset = 1'b1;
        qa.delete();
        repeat (3) applyStimulus();
        reset = 1'b0;
        applyStimulus();
        checkOutput("rst2_ff_en", 32'(ff_en_a), 32'd0);
        checkOutput("rst2_start", 32'(start_a), 32'd0);
        checkOutput("rst2_level", 32'(level_a), 32'd0);
        checkOutput("rst2_empty", 32'(empty_a), 32'd1);
        checkOutput("rst2_underrun", 32'(underrun_a), 32'd0);
        checkOutput("rst2_overflow", 32'(overflow_a), 32'd0);
        en_before = en_count_a;
        repeat (10) applyStimulus();
        checkOutput("rst2_quiet", 32'(en_count_a), 32'(en_before));

        // Fill to DEPTH, overflow on the 65th write, drain across the write-pointer wrap.
        for (int n = 1; n <= 65; n++) begin
            wr_en_b = 1'b1;
            wr_data_b = 8'(n);
            if (n <= 64) pushByte(8'(n), 1'b1);
            applyStimulus();
            if (n == 63) checkOutput("full_pre", 32'(wr_full_b), 32'd0);
            if (n == 64) begin
                checkOutput("full_level", 32'(level_b), 32'd64);
                checkOutput("full_flag", 32'(wr_full_b), 32'd1);
                checkOutput("full_ovf_pre", 32'(overflow_b), 32'd0);
                checkOutput("full_start_pre", 32'(start_b), 32'd0);
            end
            if (n == 65) begin
                checkOutput("ovf_flag", 32'(overflow_b), 32'd1);
                checkOutput("ovf_level", 32'(level_b), 32'd63);
                checkOutput("ovf_start", 32'(start_b), 32'd1);
                checkOutput("ovf_full_clr", 32'(wr_full_b), 32'd0);
            end
        end
        wr_en_b = 1'b0;
        for (int k = 0; k < 800 && qb.size() > 0; k++) applyStimulus();
        checkOutput("wrap_queue_drained", 32'(qb.size()), 32'd0);
        checkOutput("wrap_en_count", 32'(en_count_b), 32'd512);
        applyStimulus();
        checkOutput("wrap_en_fall", 32'(ff_en_b), 32'd0);
        checkOutput("wrap_underrun", 32'(underrun_b), 32'd1);
        checkOutput("wrap_level", 32'(level_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
